// File: rtl/cmd_phys_sequencer.sv
// cmd_phys_sequencer: sequences the SD host CMD-line physical layer, one command at a time.
//   A request from the CMD control layer enables the CMD transmitter. The response receiver
//   is then armed, unless the command expects no response. The captured response goes back
//   to the control layer through a strobe/ack handshake.
//
// Optional feature macro: CMD_RESP_TIMEOUT_EN
//   Defined   : a response timeout counter is built and drives timeout_error.
//   Undefined : WAIT_RESP waits indefinitely, and timeout_error is tied to 0.
//
// Ports (all logic on the rising edge of sd_clock, synchronous active-high reset):
//   sd_clock, reset                     clock and synchronous reset
//   strobe_in, ack_in, idle_in          control-layer request, acknowledge and abort
//   no_response                         command expects no response (latched on accept)
//   pad_response[RESP_WIDTH]            parallel response from the CMD receiver
//   transmission_complete               CMD transmitter done
//   reception_complete                  CMD receiver holds a complete response
//   enable_tx, enable_rx                transmitter / receiver enables
//   strobe_out, response[RESP_WIDTH]    result toward the control layer
//   timeout_error                       last command timed out
//   idle_out                            sequencer idle
module cmd_phys_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TIMER_WIDTH    = 8,
  parameter int unsigned RESP_WIDTH     = 136
) (
  input  logic                  sd_clock,
  input  logic                  reset,
  input  logic                  strobe_in,
  input  logic                  ack_in,
  input  logic                  idle_in,
  input  logic                  no_response,
  input  logic [RESP_WIDTH-1:0] pad_response,
  input  logic                  transmission_complete,
  input  logic                  reception_complete,
  output logic                  enable_tx,
  output logic                  enable_rx,
  output logic                  strobe_out,
  output logic [RESP_WIDTH-1:0] response,
  output logic                  timeout_error,
  output logic                  idle_out
);

  // Elaboration-time check of the timeout range. The check also keeps both timer parameters
  // referenced when the timeout feature is compiled out.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** TIMER_WIDTH) - 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range for TIMER_WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StSend, StWaitResp, StDone} state_e;

  state_e                state_q, state_d;
  logic                  no_resp_q, no_resp_d;
  logic [RESP_WIDTH-1:0] response_q, response_d;
  logic                  enable_tx_q, enable_rx_q, strobe_out_q, idle_out_q;

`ifdef CMD_RESP_TIMEOUT_EN
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   timeout_q, timeout_d;
  logic                   timer_expired;

  assign timer_expired = (timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d    = state_q;
    no_resp_d  = no_resp_q;
    response_d = response_q;
`ifdef CMD_RESP_TIMEOUT_EN
    timer_d    = timer_q;
    timeout_d  = timeout_q;
`endif
    // Abort overrides every non-idle state; response and timeout status are held.
    if (idle_in && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          // ack_in low is required so a strobe still held during the ack tail cannot retrigger.
          if (strobe_in && !ack_in && !idle_in) begin
            state_d    = StSend;
            no_resp_d  = no_response;
            response_d = '0;
`ifdef CMD_RESP_TIMEOUT_EN
            timeout_d  = 1'b0;
`endif
          end
        end
        StSend: begin
          if (transmission_complete) begin
            if (no_resp_q) begin
              state_d = StDone;
            end else begin
              state_d = StWaitResp;
`ifdef CMD_RESP_TIMEOUT_EN
              timer_d = '0;
`endif
            end
          end
        end
        StWaitResp: begin
          // Reception wins over a timeout landing in the same cycle.
          if (reception_complete) begin
            response_d = pad_response;
            state_d    = StDone;
`ifdef CMD_RESP_TIMEOUT_EN
          end else if (timer_expired) begin
            timeout_d = 1'b1;
            state_d   = StDone;
          end else if (timer_q != '1) begin
            timer_d = timer_q + TIMER_WIDTH'(1);
`endif
          end
        end
        StDone: begin
          if (ack_in) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered and decoded from the next state, giving one-cycle latency.
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_q      <= StIdle;
      no_resp_q    <= 1'b0;
      response_q   <= '0;
      enable_tx_q  <= 1'b0;
      enable_rx_q  <= 1'b0;
      strobe_out_q <= 1'b0;
      idle_out_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      no_resp_q    <= no_resp_d;
      response_q   <= response_d;
      enable_tx_q  <= (state_d == StSend);
      enable_rx_q  <= (state_d == StWaitResp);
      strobe_out_q <= (state_d == StDone);
      idle_out_q   <= (state_d == StIdle);
    end
  end

`ifdef CMD_RESP_TIMEOUT_EN
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_error = timeout_q;
`else
  assign timeout_error = 1'b0;
`endif

  assign enable_tx  = enable_tx_q;
  assign enable_rx  = enable_rx_q;
  assign strobe_out = strobe_out_q;
  assign idle_out   = idle_out_q;
  assign response   = response_q;

endmodule

// File: tb/tb_cmd_phys_sequencer.sv
// Directed self-checking bench for cmd_phys_sequencer. Inputs change 1 time unit after a
// rising edge, and outputs are checked at that same point, well away from the edge.
module tb_cmd_phys_sequencer;

  localparam int unsigned RespWidth = 136;
  localparam int unsigned Timeout   = 64;

  logic                 sd_clock = 1'b0;
  logic                 reset, strobe_in, ack_in, idle_in, no_response;
  logic [RespWidth-1:0] pad_response;
  logic                 transmission_complete, reception_complete;
  logic                 enable_tx, enable_rx, strobe_out, timeout_error, idle_out;
  logic [RespWidth-1:0] response;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  localparam logic [RespWidth-1:0] RespA = 136'hFFFF9999EEEE8888DDDD7777CCCC6666BB;
  localparam logic [RespWidth-1:0] RespB = 136'h3F0123456789ABCDEF0011223344556677;

  cmd_phys_sequencer #(
    .TIMEOUT_CYCLES(Timeout),
    .TIMER_WIDTH   (8),
    .RESP_WIDTH    (RespWidth)
  ) u_dut (
    .sd_clock             (sd_clock),
    .reset                (reset),
    .strobe_in            (strobe_in),
    .ack_in               (ack_in),
    .idle_in              (idle_in),
    .no_response          (no_response),
    .pad_response         (pad_response),
    .transmission_complete(transmission_complete),
    .reception_complete   (reception_complete),
    .enable_tx            (enable_tx),
    .enable_rx            (enable_rx),
    .strobe_out           (strobe_out),
    .response             (response),
    .timeout_error        (timeout_error),
    .idle_out             (idle_out)
  );

  always #5 sd_clock = ~sd_clock;

  task automatic check_eq(input string tag, input logic [RespWidth-1:0] got,
                          input logic [RespWidth-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge sd_clock);
    #1;
  endtask

  // Accept a command from IDLE and leave the bench in SEND with strobe_in released.
  task automatic start_cmd(input logic no_resp);
    strobe_in   = 1'b1;
    no_response = no_resp;
    step();
    strobe_in   = 1'b0;
    no_response = 1'b0;
  endtask

  task automatic finish_tx();
    transmission_complete = 1'b1;
    step();
    transmission_complete = 1'b0;
  endtask

  task automatic ack_done();
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
  endtask

  initial begin
    int cnt;
    int seen;
    reset = 1'b1; strobe_in = 1'b0; ack_in = 1'b0; idle_in = 1'b0; no_response = 1'b0;
    pad_response = '0; transmission_complete = 1'b0; reception_complete = 1'b0;
    step();
    step();
    check_eq("rst_idle_out", idle_out, 1);
    check_eq("rst_enable_tx", enable_tx, 0);
    check_eq("rst_enable_rx", enable_rx, 0);
    check_eq("rst_strobe_out", strobe_out, 0);
    check_eq("rst_response", response, 0);
    check_eq("rst_timeout", timeout_error, 0);
    reset = 1'b0;
    // A stray transmission_complete in IDLE must be ignored.
    transmission_complete = 1'b1;
    step();
    transmission_complete = 1'b0;
    check_eq("idle_ignores_tc", idle_out, 1);

    // Normal command with response.
    start_cmd(1'b0);
    check_eq("norm_tx_after_accept", enable_tx, 1);
    check_eq("norm_not_idle", idle_out, 0);
    repeat (19) step();
    check_eq("norm_tx_held", enable_tx, 1);
    check_eq("norm_rx_not_yet", enable_rx, 0);
    finish_tx();
    check_eq("norm_rx_on", enable_rx, 1);
    check_eq("norm_tx_off", enable_tx, 0);
    repeat (3) step();
    pad_response = RespA;
    reception_complete = 1'b1;
    step();
    reception_complete = 1'b0;
    pad_response = '0;
    check_eq("norm_strobe", strobe_out, 1);
    check_eq("norm_response", response, RespA);
    check_eq("norm_rx_off", enable_rx, 0);
    check_eq("norm_no_timeout", timeout_error, 0);
    step();
    check_eq("norm_strobe_held", strobe_out, 1);
    check_eq("norm_response_held", response, RespA);
    // Ack while strobe_in stays high: go IDLE and do not retrigger.
    ack_in = 1'b1;
    strobe_in = 1'b1;
    step();
    check_eq("norm_idle_after_ack", idle_out, 1);
    check_eq("norm_strobe_dropped", strobe_out, 0);
    check_eq("norm_resp_kept", response, RespA);
    repeat (3) step();
    check_eq("ack_blocks_retrigger_idle", idle_out, 1);
    check_eq("ack_blocks_retrigger_tx", enable_tx, 0);
    ack_in = 1'b0;
    strobe_in = 1'b0;
    step();

    // No-response command.
    start_cmd(1'b1);
    check_eq("nr_tx", enable_tx, 1);
    check_eq("nr_resp_cleared", response, 0);
    finish_tx();
    check_eq("nr_strobe", strobe_out, 1);
    check_eq("nr_rx_never", enable_rx, 0);
    check_eq("nr_response_zero", response, 0);
    ack_done();
    check_eq("nr_idle", idle_out, 1);

`ifdef CMD_RESP_TIMEOUT_EN
    // Timeout: enable_rx must stay high for exactly Timeout cycles.
    start_cmd(1'b0);
    finish_tx();
    cnt = 0;
    while (enable_rx && cnt < 200) begin
      cnt++;
      step();
    end
    check_eq("to_rx_cycles", RespWidth'(cnt), RespWidth'(Timeout));
    check_eq("to_strobe", strobe_out, 1);
    check_eq("to_error", timeout_error, 1);
    ack_done();
    // Reception on the last cycle wins over the timeout.
    start_cmd(1'b0);
    check_eq("to2_error_cleared", timeout_error, 0);
    finish_tx();
    repeat (Timeout - 1) step();
    check_eq("to2_rx_last_cycle", enable_rx, 1);
    pad_response = RespB;
    reception_complete = 1'b1;
    step();
    reception_complete = 1'b0;
    pad_response = '0;
    check_eq("to2_strobe", strobe_out, 1);
    check_eq("to2_no_error", timeout_error, 0);
    check_eq("to2_response", response, RespB);
    ack_done();
`else
    // Without the timeout feature WAIT_RESP must outlast the timeout value.
    start_cmd(1'b0);
    finish_tx();
    repeat (Timeout + 36) step();
    check_eq("nto_rx_still_on", enable_rx, 1);
    check_eq("nto_no_strobe", strobe_out, 0);
    check_eq("nto_no_error", timeout_error, 0);
    idle_in = 1'b1;
    step();
    idle_in = 1'b0;
    check_eq("nto_abort_idle", idle_out, 1);
`endif

    // Abort while waiting for a response.
    start_cmd(1'b0);
    finish_tx();
    repeat (4) step();
    check_eq("ab_rx_on", enable_rx, 1);
    idle_in = 1'b1;
    step();
    idle_in = 1'b0;
    check_eq("ab_idle", idle_out, 1);
    check_eq("ab_rx_off", enable_rx, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      // A late reception_complete in IDLE must not produce a strobe.
      reception_complete = (i == 2);
      pad_response = RespB;
      step();
      if (strobe_out) seen = 1;
    end
    reception_complete = 1'b0;
    check_eq("ab_no_strobe", RespWidth'(seen), 0);
    check_eq("ab_resp_held", response, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
